haar_stage_sequencer: RTL and testbench

Sequencing controller for one Haar-transform stage built from four sample FIFOs and three demultiplexers. It steers an incoming block of N samples into the FIFOs by even/odd index and by half-block, then drains the FIFOs in pairs into the sum/difference datapath. It pulses `done` when the block is finished. It is the parameterised, handshaked successor to the fixed first-stage controller and sits between the sample source and the FIFO/demux datapath of a stage.

---
 rtl/haar_stage_sequencer.sv | 142 ++++++++++++++
 tb/tb_haar_stage_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_stage_sequencer.sv
// haar_stage_sequencer
//
// Sequencing controller for one Haar-transform stage. An incoming block of
// N samples is steered into four FIFOs by even/odd sample index and by
// half-block (FIFO1/2 take the first half, FIFO3/4 the second). The FIFOs
// are then drained in pairs (1&2, then 3&4) into the sum/difference
// datapath. `done` pulses for one cycle when the block is finished.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a block (sampled only in IDLE)
//   in_valid                  input sample present (sampled only in FILL)
//   out_ready                 downstream accepts a pair (sampled only in DRAIN)
//   write_FIFO1..4            FIFO write enables (Mealy on in_valid)
//   read_FIFO1..4             FIFO read enables, always in pairs (Mealy on out_ready)
//   sel_demux1                input routing: 0 = even FIFO, 1 = odd FIFO
//   sel_demux2                input half-block routing: 0 = FIFO1/2, 1 = FIFO3/4
//   sel_demux3                drain pair routing: 0 = FIFO1/2, 1 = FIFO3/4
//   out_valid                 FIFO pair valid at datapath (read enable delayed 1)
//   busy                      high in FILL, DRAIN and DONE
//   done                      one-cycle pulse at end of block
module haar_stage_sequencer #(
    parameter int N     = 16,
    parameter int LOG2N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic out_ready,
    output logic write_FIFO1,
    output logic write_FIFO2,
    output logic write_FIFO3,
    output logic write_FIFO4,
    output logic read_FIFO1,
    output logic read_FIFO2,
    output logic read_FIFO3,
    output logic read_FIFO4,
    output logic sel_demux1,
    output logic sel_demux2,
    output logic sel_demux3,
    output logic out_valid,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] LAST_RD  = (LOG2N - 1)'(N / 2 - 1);

    state_t           state;
    logic [LOG2N-1:0] idx;
    logic [LOG2N-2:0] rd;

    logic fill_wr;
    logic drain_rd;
    logic idx_odd;
    logic idx_upper;
    logic rd_upper;

    assign fill_wr   = (state == FILL) && in_valid;
    assign drain_rd  = (state == DRAIN) && out_ready;
    assign idx_odd   = idx[0];
    // MSB of idx set means idx >= N/2; MSB of rd set means rd >= N/4.
    assign idx_upper = idx[LOG2N-1];
    assign rd_upper  = rd[LOG2N-2];

    always_comb begin
        sel_demux1  = (state == FILL) && idx_odd;
        sel_demux2  = (state == FILL) && idx_upper;
        sel_demux3  = (state == DRAIN) && rd_upper;

        write_FIFO1 = fill_wr && !idx_odd && !idx_upper;
        write_FIFO2 = fill_wr &&  idx_odd && !idx_upper;
        write_FIFO3 = fill_wr && !idx_odd &&  idx_upper;
        write_FIFO4 = fill_wr &&  idx_odd &&  idx_upper;

        read_FIFO1  = drain_rd && !rd_upper;
        read_FIFO2  = drain_rd && !rd_upper;
        read_FIFO3  = drain_rd &&  rd_upper;
        read_FIFO4  = drain_rd &&  rd_upper;
    end

    // busy and done are registered alongside the state so that they track
    // the state register exactly, without a combinational decode on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rd        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // FIFOs have one-cycle read latency.
            out_valid <= drain_rd;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        idx   <= '0;
                        rd    <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        idx <= idx + LOG2N'(1);
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd <= rd + (LOG2N - 1)'(1);
                        if (rd == LAST_RD) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// tb_haar_stage_sequencer
//
// Scoreboard bench for haar_stage_sequencer (N=16). The stimulus process
// drives directed blocks cycle by cycle and queues the expected output
// vector for every cycle in which the DUT should show activity; a monitor
// on the falling edge pops and compares whenever the DUT shows activity or
// an expected vector falls due.
module tb_haar_stage_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;
    logic out_ready;
    logic write_FIFO1, write_FIFO2, write_FIFO3, write_FIFO4;
    logic read_FIFO1, read_FIFO2, read_FIFO3, read_FIFO4;
    logic sel_demux1, sel_demux2, sel_demux3;
    logic out_valid, busy, done;

    haar_stage_sequencer #(
        .N    (16),
        .LOG2N(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .write_FIFO1(write_FIFO1),
        .write_FIFO2(write_FIFO2),
        .write_FIFO3(write_FIFO3),
        .write_FIFO4(write_FIFO4),
        .read_FIFO1 (read_FIFO1),
        .read_FIFO2 (read_FIFO2),
        .read_FIFO3 (read_FIFO3),
        .read_FIFO4 (read_FIFO4),
        .sel_demux1 (sel_demux1),
        .sel_demux2 (sel_demux2),
        .sel_demux3 (sel_demux3),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] wr;
        logic [3:0] rd;
        logic       s1;
        logic       s2;
        logic       s3;
        logic       ov;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_fail    = 0;
    int   last_done = -1;
    logic mon_en    = 1'b0;

    // Hand-computed FIFO number for each sample index of a 16-sample block.
    int fill_pat[16] = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 4, 3, 4, 3, 4, 3, 4};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] act_vec();
        return {write_FIFO4, write_FIFO3, write_FIFO2, write_FIFO1,
                read_FIFO4, read_FIFO3, read_FIFO2, read_FIFO1,
                sel_demux1, sel_demux2, sel_demux3, out_valid, busy, done};
    endfunction

    function automatic void expect_vec(int c, logic [3:0] w, logic [3:0] r,
                                       logic s1, logic s2, logic s3,
                                       logic ov, logic b, logic d);
        exp_t e;
        if (!((|w) || (|r) || ov || d)) return;
        e.cyc = c; e.wr = w; e.rd = r; e.s1 = s1; e.s2 = s2; e.s3 = s3;
        e.ov = ov; e.bsy = b; e.dn = d;
        q.push_back(e);
    endfunction

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        logic [3:0]  awr;
        logic [3:0]  ard;
        logic [13:0] av;
        logic [13:0] ev;
        logic        trig;
        exp_t        e;
        if (mon_en) begin
            awr  = {write_FIFO4, write_FIFO3, write_FIFO2, write_FIFO1};
            ard  = {read_FIFO4, read_FIFO3, read_FIFO2, read_FIFO1};
            av   = act_vec();
            trig = (|awr) || (|ard) || out_valid || done;
            if (done === 1'b1) last_done = cyc;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_vec++; n_fail++;
                $display("FAIL missing_event cycle=%0d: expected activity at cycle %0d, saw none",
                         cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e  = q.pop_front();
                ev = {e.wr, e.rd, e.s1, e.s2, e.s3, e.ov, e.bsy, e.dn};
                n_vec++;
                if (av !== ev) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle=%0d: got wr/rd/s1s2s3/ov/busy/done=%b required %b",
                             cyc, av, ev);
                end
            end else if (trig) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_event cycle=%0d: got %b required no activity", cyc, av);
            end
            n_vec++;
            if (((|awr) && (|ard)) || ($countones(awr) > 1) ||
                !(ard == 4'b0000 || ard == 4'b0011 || ard == 4'b1100)) begin
                n_fail++;
                $display("FAIL enable_invariant cycle=%0d: got wr=%b rd=%b required exclusive/paired",
                         cyc, awr, ard);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        #2;
        n_vec++;
        if (act_vec() !== 14'd0) begin
            n_fail++;
            $display("FAIL %s cycle=%0d: got outputs=%b required all zero", name, cyc, act_vec());
        end
    endtask

    // One block: stall_in toggles in_valid 1,0 during FILL; out_ready drops
    // for bp_len cycles when bp_at pairs have been read; poke drives the
    // controls that must be ignored in each state.
    task automatic run_block(input string name, input bit stall_in,
                             input int bp_at, input int bp_len, input bit poke);
        int         t;
        int         i;
        int         ph;
        int         rdc;
        int         stall_left;
        bit         prev_rd;
        bit         iv;
        bit         ordy;
        logic [3:0] w;
        logic [3:0] r;
        int         exp_done;
        last_done = -1;
        step();
        t = cyc;
        start = 1'b1; in_valid = poke; out_ready = poke;
        step();
        // FILL
        i = 0; ph = 0;
        while (i < 16) begin
            iv = stall_in ? (ph % 2 == 0) : 1'b1;
            ph++;
            start = poke; in_valid = iv; out_ready = poke ? ph[0] : 1'b1;
            if (iv) begin
                w = 4'b0001 << (fill_pat[i] - 1);
                expect_vec(cyc, w, 4'b0000, (i % 2) == 1, i >= 8, 1'b0, 1'b0, 1'b1, 1'b0);
                i++;
            end
            step();
        end
        // DRAIN
        rdc = 0; prev_rd = 1'b0; stall_left = bp_len;
        while (rdc < 8) begin
            ordy = 1'b1;
            if (rdc == bp_at && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            start = poke; in_valid = poke; out_ready = ordy;
            r = ordy ? ((rdc < 4) ? 4'b0011 : 4'b1100) : 4'b0000;
            expect_vec(cyc, 4'b0000, r, 1'b0, 1'b0, rdc >= 4, prev_rd, 1'b1, 1'b0);
            prev_rd = ordy;
            if (ordy) rdc++;
            step();
        end
        // DONE
        start = poke; in_valid = poke; out_ready = 1'b1;
        expect_vec(cyc, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, prev_rd, 1'b1, 1'b1);
        step();
        // Back in IDLE
        start = 1'b0; in_valid = poke; out_ready = poke;
        #2;
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after_done cycle=%0d: got busy=%b required 0", name, cyc, busy);
        end
        exp_done = t + 25 + (stall_in ? 15 : 0) + bp_len;
        n_vec++;
        if (last_done != exp_done) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got done at cycle %0d required %0d", name, last_done, exp_done);
        end
        step();
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        // Reset with random inputs.
        repeat (2) begin
            @(posedge clk);
            #1;
            start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
        end
        chk_zero("reset_outputs");
        #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (10) begin
            step();
            chk_zero("idle_after_reset");
        end

        run_block("nominal", 1'b0, -1, 0, 1'b0);
        run_block("input_stall", 1'b1, -1, 0, 1'b0);
        run_block("backpressure", 1'b0, 2, 3, 1'b0);
        run_block("ignored_ctrl", 1'b0, -1, 0, 1'b1);

        // Reset after 7 writes.
        step();
        t = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            expect_vec(cyc, 4'b0001 << (fill_pat[k] - 1), 4'b0000, (k % 2) == 1, 1'b0,
                       1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("mid_block_reset");
        run_block("after_reset", 1'b0, -1, 0, 1'b0);

        repeat (4) step();
        n_vec++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected vectors required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
